// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter putting an IFU fetch port and an LSU load/store port onto one memory port.
// Latency: grant-to-issue 1 cycle, response forwarded combinationally, at least 3 cycles per transaction.
// Backpressure: mem_req_ready stalls ISSUE; one transaction outstanding; WAIT ends with an error response after TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_err
);

  // Counter only ever reaches TIMEOUT-1, so this width never wraps.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_nxt;
  logic                owner;
  logic                last_grant;
  logic [CNT_W-1:0]    wait_cnt;
  logic                grant_ifu, grant_lsu;
  logic                timeout_hit, rsp_fire;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   rsp_data_mux;
  logic                rsp_err_mux;

  // Latched request fields drive the memory port directly so they stay stable while stalled.
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  // A real response always beats a coincident timeout; timeout returns zero data with err set.
  assign rsp_data_mux = mem_rsp_valid ? mem_rsp_data : '0;
  assign rsp_err_mux  = mem_rsp_valid ? mem_rsp_err  : 1'b1;
  assign ifu_rsp_data = rsp_data_mux;
  assign ifu_rsp_err  = rsp_err_mux;
  assign lsu_rsp_data = rsp_data_mux;
  assign lsu_rsp_err  = rsp_err_mux;

  // Next-state, grant and response decode.
  always_comb begin
    state_nxt     = state;
    grant_ifu     = 1'b0;
    grant_lsu     = 1'b0;
    timeout_hit   = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    rsp_fire      = (state == WAIT) && (mem_rsp_valid || timeout_hit);
    mem_req_valid = (state == ISSUE);
    case (state)
      IDLE: begin
        // IFU wins unless LSU also asks and IFU had the last grant.
        grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant == OWN_LSU));
        grant_lsu = lsu_req_valid && !grant_ifu;
        if (grant_ifu || grant_lsu) state_nxt = ISSUE;
      end
      ISSUE: if (mem_req_ready) state_nxt = WAIT;
      WAIT:  if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ifu_req_ready = grant_ifu;
    lsu_req_ready = grant_lsu;
    ifu_rsp_valid = rsp_fire && (owner == OWN_IFU);
    lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
  end

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the granted request and remember who won for round-robin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      owner      <= OWN_IFU;
      last_grant <= OWN_LSU;
    end else if (grant_ifu) begin
      addr_q     <= ifu_req_addr;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
    end else if (grant_lsu) begin
      addr_q     <= lsu_req_addr;
      wen_q      <= lsu_req_wen;
      wdata_q    <= lsu_req_wdata;
      wmask_q    <= lsu_req_wmask;
      owner      <= OWN_LSU;
      last_grant <= OWN_LSU;
    end
  end

  // WAIT cycle counter: cleared on entry, counts response-less WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE && mem_req_ready) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !rsp_fire) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    logic        lsu;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory-side monitor: each accepted request must match the next expected one.
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      if (exp_req.size() == 0) begin
        chk("unexpected_mem_req", {32'h0, mem_req_addr}, 64'h0);
      end else begin
        req_t e;
        e = exp_req.pop_front();
        chk("mem_req_addr", {32'h0, mem_req_addr}, {32'h0, e.addr});
        chk("mem_req_wen", {63'h0, mem_req_wen}, {63'h0, e.wen});
        chk("mem_req_wmask", {60'h0, mem_req_wmask}, {60'h0, e.wmask});
        if (e.wen) chk("mem_req_wdata", {32'h0, mem_req_wdata}, {32'h0, e.wdata});
      end
    end
  end

  // Response monitor: any response pulse must match the next expected one.
  always @(negedge clk) begin
    if (!rst && (ifu_rsp_valid || lsu_rsp_valid)) begin
      if (exp_rsp.size() == 0) begin
        chk("unexpected_rsp", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
      end else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        chk("rsp_port", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, {62'h0, !e.lsu, e.lsu});
        chk("rsp_data", {32'h0, e.lsu ? lsu_rsp_data : ifu_rsp_data}, {32'h0, e.data});
        chk("rsp_err", {63'h0, e.lsu ? lsu_rsp_err : ifu_rsp_err}, {63'h0, e.err});
      end
    end
  end

  // Issue one request, stall the memory port 'stall' cycles, return in WAIT cycle 1.
  task automatic run_req(input bit lsu, input logic [31:0] addr, input bit wen,
                         input logic [31:0] wdata, input logic [3:0] wmask, input int stall);
    req_t r;
    r.addr  = addr;
    r.wen   = lsu ? wen : 1'b0;
    r.wdata = wdata;
    r.wmask = lsu ? wmask : 4'h0;
    exp_req.push_back(r);
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_req_addr = addr; lsu_req_wen = wen;
      lsu_req_wdata = wdata; lsu_req_wmask = wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_req_addr = addr;
    end
    @(negedge clk);
    chk("req_ready", {62'h0, ifu_req_ready, lsu_req_ready}, {62'h0, !lsu, lsu});
    cyc();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("issue_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("issue_addr_stable", {32'h0, mem_req_addr}, {32'h0, r.addr});
      chk("issue_wmask_stable", {60'h0, mem_req_wmask}, {60'h0, r.wmask});
      cyc();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("issue_valid", {63'h0, mem_req_valid}, 64'h1);
    cyc();
    mem_req_ready = 1'b0;
  endtask

  // Idle 'lat' WAIT cycles, then either drive a memory response or rely on timeout.
  task automatic wait_rsp(input bit lsu, input int lat, input logic [31:0] data,
                          input bit err, input bit give);
    rsp_t e;
    e.lsu  = lsu;
    e.data = give ? data : 32'h0;
    e.err  = give ? err : 1'b1;
    exp_rsp.push_back(e);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("no_early_rsp", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
      cyc();
    end
    mem_rsp_valid = give; mem_rsp_data = data; mem_rsp_err = err;
    @(negedge clk);
    chk("rsp_pulse", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, {62'h0, !lsu, lsu});
    cyc();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("back_idle_no_rsp", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req_valid", {63'h0, mem_req_valid}, 64'h0);
    chk("rst_rsp_valid", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
    chk("rst_latched", {27'h0, mem_req_wen, mem_req_wmask, mem_req_addr}, 64'h0);
    cyc();
    rst = 1'b0;

    // Contention straight after reset: IFU, LSU, IFU, LSU; mem_rsp_valid held high throughout.
    ifu_req_valid = 1; ifu_req_addr = 32'h0000_1000;
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_2000; lsu_req_wen = 1;
    lsu_req_wdata = 32'h1111_2222; lsu_req_wmask = 4'h3;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_00AB; mem_rsp_err = 0;
    for (int k = 0; k < 4; k++) begin
      req_t r;
      rsp_t s;
      r.addr  = (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
      r.wen   = (k % 2 == 1);
      r.wdata = 32'h1111_2222;
      r.wmask = (k % 2 == 1) ? 4'h3 : 4'h0;
      exp_req.push_back(r);
      s.lsu = (k % 2 == 1); s.data = 32'h0000_00AB; s.err = 1'b0;
      exp_rsp.push_back(s);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0)
        chk("rr_grant", {62'h0, ifu_req_ready, lsu_req_ready},
            (c % 6 == 0) ? 64'h2 : 64'h1);
      else
        chk("busy_no_ready", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h0);
      cyc();
      if (c == 9) begin ifu_req_valid = 0; lsu_req_valid = 0; end
    end
    mem_req_ready = 0; mem_rsp_valid = 0;
    cyc();

    // LSU store with 3 stall cycles (4 ISSUE cycles), response after one idle WAIT cycle.
    run_req(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 3);
    wait_rsp(1, 1, 32'h0000_CAFE, 0, 1);

    // IFU read: ISSUE at T+1, response at T+2; wmask must be cleared after the store.
    run_req(0, 32'h8000_0000, 0, 32'h0, 4'h0, 0);
    wait_rsp(0, 0, 32'h0000_0413, 0, 1);

    // LSU load with no memory response: timeout on WAIT cycle 4.
    run_req(1, 32'h8000_2000, 0, 32'h0, 4'h0, 0);
    wait_rsp(1, 3, 32'h0, 0, 0);

    // Real response coinciding with the timeout cycle wins.
    run_req(1, 32'h8000_3000, 0, 32'h0, 4'h0, 1);
    wait_rsp(1, 3, 32'h0000_1234, 0, 1);

    // Error response passed through from memory.
    run_req(0, 32'h8000_0004, 0, 32'h0, 4'h0, 0);
    wait_rsp(0, 2, 32'h5555_AAAA, 1, 1);

    // Reset during WAIT, then a late memory response must be dropped.
    run_req(0, 32'h8000_0100, 0, 32'h0, 4'h0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", {30'h0, mem_req_valid, ifu_rsp_valid, mem_req_addr}, 64'h0);
    cyc();
    rst = 1'b0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h7777_7777; mem_rsp_err = 0;
    @(negedge clk);
    chk("late_rsp_ignored", {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
    cyc();
    mem_rsp_valid = 0;
    run_req(0, 32'h8000_0200, 0, 32'h0, 4'h0, 0);
    wait_rsp(0, 0, 32'h0000_0093, 0, 1);

    repeat (2) cyc();
    chk("req_queue_drained", exp_req.size(), 64'h0);
    chk("rsp_queue_drained", exp_rsp.size(), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
